// File: rtl/gmii_mon_pkg.sv
// Shared types and constants for the GMII receive monitor.
package gmii_mon_pkg;

   // Checker FSM states.
   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_IDLE = 3'd1,
      ST_PRE  = 3'd2,
      ST_DATA = 3'd3,
      ST_DROP = 3'd4
   } mon_state_t;

   // bad_cause codes reported alongside frame_ok / frame_bad.
   localparam logic [2:0] CAUSE_OK       = 3'd0;
   localparam logic [2:0] CAUSE_RXER     = 3'd1;
   localparam logic [2:0] CAUSE_CRC      = 3'd2;
   localparam logic [2:0] CAUSE_RUNT     = 3'd3;
   localparam logic [2:0] CAUSE_GIANT    = 3'd4;
   localparam logic [2:0] CAUSE_PREAMBLE = 3'd5;

   localparam logic [7:0]  PREAMBLE    = 8'h55;
   localparam logic [7:0]  SFD         = 8'hD5;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   // Byte counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC-32, LSB of the byte first.
module crc32_d8
   import gmii_mon_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [7:0]  data,
   output logic [31:0] crc_next
);

   logic [31:0] c;

   // Shift the eight data bits through the register one at a time.
   always_comb begin
      c = crc;
      for (int i = 0; i < 8; i++) begin
         c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_next = c;
   end

endmodule

// File: rtl/gmii_rx_mon.sv
// Inline GMII receive monitor: one-cycle pass-through of PHY0 rx pins plus a
// frame checker (preamble/SFD, RX_ER, FCS, length), counters and a port
// health flag for the failover mux.
//
// Stream semantics: a byte on rxdat_i is valid exactly when rxdv_i is high on
// a phy0_rxclk rising edge; there is no backpressure (the monitor accepts every
// byte). rxer_i only matters while rxdv_i is high. A frame ends on the first
// edge that samples rxdv_i low. The checker FSM register is state_q.
module gmii_rx_mon
   import gmii_mon_pkg::*;
#(
   parameter int MIN_LEN       = 64,
   parameter int MAX_LEN       = 1522,
   parameter int ALIVE_TIMEOUT = 1250000,
   parameter int ERR_THRESH    = 4
)(
   input  logic        rst,
   input  logic        phy0_rxclk,
   input  logic [7:0]  rxdat_i,
   input  logic        rxdv_i,
   input  logic        rxer_i,
   output logic [7:0]  rxdat_o,
   output logic        rxdv_o,
   output logic        rxer_o,
   output logic        frame_ok,
   output logic        frame_bad,
   output logic [2:0]  bad_cause,
   output logic [15:0] frame_len,
   output logic [31:0] good_cnt,
   output logic [15:0] bad_cnt,
   output logic        port_alive
);

   localparam int TMR_W = $clog2(ALIVE_TIMEOUT + 1);
   localparam int RUN_W = $clog2(ERR_THRESH + 1);
   localparam logic [15:0]      MIN_LEN_W = 16'(MIN_LEN);
   localparam logic [15:0]      MAX_LEN_W = 16'(MAX_LEN);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(ALIVE_TIMEOUT);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(ERR_THRESH);

   mon_state_t state_q, state_d;
   logic [31:0] crc_q, crc_d, crc_nxt;
   logic [15:0] len_q, len_d;
   logic        err_q, err_d;
   logic [2:0]  cause_q, cause_d;
   logic        eof;
   logic [2:0]  eof_cause;
   logic        ok_now, bad_now;
   logic [TMR_W-1:0] timer_q;
   logic [RUN_W-1:0] bad_run_q;

   crc32_d8 u_crc (
      .crc      (crc_q),
      .data     (rxdat_i),
      .crc_next (crc_nxt)
   );

   // Pass-through register, independent of the checker.
   always_ff @(posedge phy0_rxclk or posedge rst) begin
      if (rst) begin
         rxdat_o <= 8'd0;
         rxdv_o  <= 1'b0;
         rxer_o  <= 1'b0;
      end else begin
         rxdat_o <= rxdat_i;
         rxdv_o  <= rxdv_i;
         rxer_o  <= rxer_i;
      end
   end

   // Checker state and per-frame accumulators.
   always_ff @(posedge phy0_rxclk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SYNC;
         crc_q   <= CRC_INIT;
         len_q   <= 16'd0;
         err_q   <= 1'b0;
         cause_q <= CAUSE_OK;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         len_q   <= len_d;
         err_q   <= err_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic; eof/eof_cause flag the frame-end edge and its verdict.
   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      len_d     = len_q;
      err_d     = err_q;
      cause_d   = cause_q;
      eof       = 1'b0;
      eof_cause = CAUSE_OK;
      case (state_q)
         ST_SYNC: begin
            // Discard whatever is in flight after reset.
            if (!rxdv_i) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (rxdv_i) begin
               len_d = 16'd0;
               if (rxdat_i == PREAMBLE) begin
                  state_d = ST_PRE;
               end else begin
                  state_d = ST_DROP;
                  cause_d = CAUSE_PREAMBLE;
               end
            end
         end
         ST_PRE: begin
            if (!rxdv_i) begin
               eof       = 1'b1;
               eof_cause = CAUSE_PREAMBLE;
               state_d   = ST_IDLE;
            end else if (rxdat_i == SFD) begin
               state_d = ST_DATA;
               crc_d   = CRC_INIT;
               len_d   = 16'd0;
               err_d   = 1'b0;
            end else if (rxdat_i != PREAMBLE) begin
               state_d = ST_DROP;
               cause_d = CAUSE_PREAMBLE;
            end
         end
         ST_DATA: begin
            if (rxdv_i) begin
               crc_d = crc_nxt;
               len_d = sat_inc16(len_q);
               if (rxer_i) err_d = 1'b1;
            end else begin
               eof     = 1'b1;
               state_d = ST_IDLE;
               if (err_q)                    eof_cause = CAUSE_RXER;
               else if (crc_q != CRC_RESIDUE) eof_cause = CAUSE_CRC;
               else if (len_q < MIN_LEN_W)    eof_cause = CAUSE_RUNT;
               else if (len_q > MAX_LEN_W)    eof_cause = CAUSE_GIANT;
               else                           eof_cause = CAUSE_OK;
            end
         end
         ST_DROP: begin
            if (!rxdv_i) begin
               eof       = 1'b1;
               eof_cause = cause_q;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   assign ok_now  = eof && (eof_cause == CAUSE_OK);
   assign bad_now = eof && (eof_cause != CAUSE_OK);

   // Frame report: pulses plus cause/length for the cycle after frame end.
   always_ff @(posedge phy0_rxclk or posedge rst) begin
      if (rst) begin
         frame_ok  <= 1'b0;
         frame_bad <= 1'b0;
         bad_cause <= CAUSE_OK;
         frame_len <= 16'd0;
      end else begin
         frame_ok  <= ok_now;
         frame_bad <= bad_now;
         bad_cause <= eof ? eof_cause : CAUSE_OK;
         frame_len <= eof ? len_q : 16'd0;
      end
   end

   // Counters, idle timer, consecutive-bad run and the health flag.
   always_ff @(posedge phy0_rxclk or posedge rst) begin
      if (rst) begin
         good_cnt   <= 32'd0;
         bad_cnt    <= 16'd0;
         timer_q    <= '0;
         bad_run_q  <= '0;
         port_alive <= 1'b0;
      end else begin
         if (ok_now) good_cnt <= good_cnt + 32'd1;
         if (bad_now && bad_cnt != 16'hFFFF) bad_cnt <= bad_cnt + 16'd1;

         if (ok_now)                  timer_q <= '0;
         else if (timer_q != TMR_MAX) timer_q <= timer_q + 1'b1;

         if (ok_now)                           bad_run_q <= '0;
         else if (bad_now && bad_run_q != RUN_MAX) bad_run_q <= bad_run_q + 1'b1;

         // A good frame on the expiry edge keeps the port alive.
         if (ok_now)
            port_alive <= 1'b1;
         else if ((bad_now && bad_run_q >= RUN_MAX - 1'b1) ||
                  (timer_q == TMR_MAX - 1'b1))
            port_alive <= 1'b0;
      end
   end

endmodule
